// File: rtl/bits_to_bin.sv
// Unary bitstream to binary converter: counts the ones in a window of 2^CWID
// qualified bits and reports the count with the sign captured on the last bit.
module bits_to_bin #(
  parameter int CWID = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            en,
  input  logic            bit_in,
  input  logic            sign_in,
  output logic            busy,
  output logic            done,
  output logic [CWID:0]   result,
  output logic            result_sign,
  output logic [1:0]      dbg_state
);

  // Handshake: start is sampled only in IDLE or DONE (ignored during ACC);
  // bit_in/sign_in are consumed only in ACC cycles with en=1; done is a
  // one-cycle pulse and result/result_sign are valid from that cycle until
  // the next done.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CWID:0] LAST = {1'b0, {CWID{1'b1}}};

  logic [1:0]    state;
  logic [CWID:0] win_cnt;
  logic [CWID:0] ones_cnt;
  logic [CWID:0] ones_next;

  always_comb begin
    ones_next = ones_cnt + {{CWID{1'b0}}, bit_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win_cnt     <= '0;
      ones_cnt    <= '0;
      result      <= '0;
      result_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            win_cnt  <= '0;
            ones_cnt <= '0;
          end
        end
        ACC: begin
          if (en) begin
            win_cnt  <= win_cnt + 1'b1;
            ones_cnt <= ones_next;
            // The N-th qualified bit closes the window, counting that bit too.
            if (win_cnt == LAST) begin
              state       <= DONE;
              result      <= ones_next;
              result_sign <= sign_in;
            end
          end
        end
        DONE: begin
          if (start) begin
            state    <= ACC;
            win_cnt  <= '0;
            ones_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from the registered state so reset clears them without a clock.
  assign busy      = (state == ACC);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_bits_to_bin.sv
// Directed self-checking bench for bits_to_bin with CWID=3 (8-bit windows).
module tb_bits_to_bin;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       en;
  logic       bit_in;
  logic       sign_in;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       result_sign;
  logic [1:0] dbg_state;

  int checks;
  int errors;

  bits_to_bin #(.CWID(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .en          (en),
    .bit_in      (bit_in),
    .sign_in     (sign_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_sign (result_sign),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; en = 1'b0; bit_in = 1'b0; sign_in = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 || result_sign !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%0d sign=%b state=%0d, want all 0",
               busy, done, result, result_sign, dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // One full window; bits[7] is the first qualified bit.
  task automatic test_window(input string name, input logic [7:0] bits, input logic sgn,
                             input bit toggle, input bit start_mid,
                             input logic [3:0] exp_res, input logic [3:0] hold);
    @(negedge clk);
    start = 1'b1; en = 1'b1; bit_in = 1'b1; sign_in = 1'b1;  // en/bit ignored here
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== hold) begin
        errors++;
        $display("FAIL %s_acc bit%0d: busy=%b done=%b result=%0d, want 1 0 %0d",
                 name, i, busy, done, result, hold);
      end
      start = start_mid; en = 1'b1; bit_in = bits[7-i]; sign_in = (i == 7) ? sgn : ~sgn;
      if (toggle && i < 7) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s_gap bit%0d: busy=%b done=%b, want 1 0", name, i, busy, done);
        end
        start = start_mid; en = 1'b0; bit_in = 1'b1; sign_in = sgn;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res || result_sign !== sgn) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b result=%0d sign=%b, want 1 0 %0d %b",
               name, done, busy, result, result_sign, exp_res, sgn);
    end
    start = 1'b0; en = 1'b1; bit_in = 1'b1; sign_in = ~sgn;  // ignored in DONE
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || result_sign !== sgn) begin
      errors++;
      $display("FAIL %s_hold: done=%b busy=%b result=%0d sign=%b, want 0 0 %0d %b",
               name, done, busy, result, result_sign, exp_res, sgn);
    end
    en = 1'b0; bit_in = 1'b0; sign_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; en = 1'b1; bit_in = 1'b0; sign_in = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      checks++;
      if (done !== (k % 9 == 0) || (done === 1'b1 && result !== 4'd0)) begin
        errors++;
        $display("FAIL b2b cycle%0d: done=%b result=%0d, want done=%b result=0",
                 k, done, result, (k % 9 == 0));
      end
    end
    start = 1'b0; en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_mid_reset();
    // Leave a nonzero result first so the reset clear is observable.
    test_window("pre_rst", 8'b11111110, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0);
    @(negedge clk);
    start = 1'b1; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0; en = 1'b1; bit_in = 1'b1; sign_in = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 || result_sign !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%0d sign=%b, want all 0",
               busy, done, result, result_sign);
    end
    en = 1'b0;
    // Start on the very first edge after release must be honoured.
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_release: busy=%b, want 1", busy);
    end
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    test_window("post_rst", 8'b01011101, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_window("basic",   8'b10110010, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0);
    test_window("all_one", 8'b11111111, 1'b1, 1'b0, 1'b1, 4'd8, 4'd4);
    test_window("toggle",  8'b11111111, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8);
    test_window("three",   8'b00010101, 1'b1, 1'b0, 1'b0, 4'd3, 4'd8);
    test_window("six",     8'b11011011, 1'b0, 1'b1, 1'b1, 4'd6, 4'd3);
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
